// File: rtl/seq_table_gen.sv
// Table-driven sequence generator: wrap, bounce and one-shot stepping.
// Optional load port set enabled by defining SEQ_TABLE_GEN_LOAD_EN.
module seq_table_gen #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          up_down,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] last_idx,
  input  logic          restart,
`ifdef SEQ_TABLE_GEN_LOAD_EN
  input  logic          load,
  input  logic [AW-1:0] load_idx,
`endif
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  seq,
  output logic [AW-1:0] idx,
  output logic          wrap,
  output logic          done
);

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  localparam logic [1:0] M_BNC = 2'b01;
  localparam logic [1:0] M_ONE = 2'b10;

  logic [W-1:0]  tbl [DEPTH];
  dir_t          dir;
  dir_t          dir_n;
  logic [AW-1:0] idx_n;
  logic          wrap_n;
  logic          done_n;
  logic          halted;

  assign seq    = tbl[idx];
  assign halted = done && (mode == M_ONE);

  // Code table: identity on reset, single write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= W'(i);
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Stepping state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      dir  <= UP;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      idx  <= idx_n;
      dir  <= dir_n;
      wrap <= wrap_n;
      done <= done_n;
    end
  end

  // Next index, direction, wrap pulse and done flag.
  always_comb begin
    idx_n  = idx;
    dir_n  = dir;
    wrap_n = 1'b0;
    done_n = done;
    if (mode != M_ONE)
      done_n = 1'b0;
    if (restart) begin
      idx_n  = '0;
      dir_n  = UP;
      done_n = 1'b0;
    end
`ifdef SEQ_TABLE_GEN_LOAD_EN
    else if (load) begin
      idx_n  = (load_idx > last_idx) ?
               last_idx : load_idx;
      done_n = 1'b0;
    end
`endif
    else if (enable && !halted) begin
      if (idx > last_idx) begin
        idx_n = '0;
        dir_n = UP;
      end else begin
        unique case (mode)
          M_BNC: begin
            if (last_idx == '0) begin
              wrap_n = 1'b1;
            end else if (dir == UP) begin
              if (idx == last_idx) begin
                idx_n  = idx - AW'(1);
                dir_n  = DN;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx + AW'(1);
              end
            end else begin
              if (idx == '0) begin
                idx_n  = AW'(1);
                dir_n  = UP;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx - AW'(1);
              end
            end
          end
          M_ONE: begin
            if (up_down && idx == last_idx) begin
              done_n = 1'b1;
              wrap_n = 1'b1;
            end else if (!up_down && idx == '0) begin
              done_n = 1'b1;
              wrap_n = 1'b1;
            end else if (up_down) begin
              idx_n = idx + AW'(1);
            end else begin
              idx_n = idx - AW'(1);
            end
          end
          default: begin
            if (up_down) begin
              if (idx == last_idx) begin
                idx_n  = '0;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx + AW'(1);
              end
            end else begin
              if (idx == '0) begin
                idx_n  = last_idx;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx - AW'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_table_gen.sv
// Directed bench for seq_table_gen (default build, W=8, DEPTH=8).
// Expected values are hand-derived per step.
module tb_seq_table_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       up_down;
  logic [1:0] mode;
  logic [2:0] last_idx;
  logic       restart;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] seq;
  logic [2:0] idx;
  logic       wrap;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  seq_table_gen #(.W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .up_down  (up_down),
    .mode     (mode),
    .last_idx (last_idx),
    .restart  (restart),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .seq      (seq),
    .idx      (idx),
    .wrap     (wrap),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int e_seq [5]  = '{1, 2, 3, 4, 0};
  int e_wr  [5]  = '{0, 0, 0, 0, 1};
  int d_seq [6]  = '{10, 7, 5, 3, 2, 10};
  int d_wr  [6]  = '{1, 0, 0, 0, 0, 1};
  int b_idx [7]  = '{1, 2, 3, 2, 1, 0, 1};
  int b_wr  [7]  = '{0, 0, 0, 1, 0, 0, 1};
  int t_dat [5]  = '{2, 3, 5, 7, 10};

  initial begin
    rst = 1'b0; enable = 1'b0; up_down = 1'b1;
    mode = 2'b00; last_idx = 3'd4; restart = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    chk("rst_idx", idx, 0);
    chk("rst_seq", seq, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    step();

    // wrap mode, up, length 5
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("up_seq%0d", i), seq, e_seq[i]);
      chk($sformatf("up_wrap%0d", i), wrap, e_wr[i]);
    end
    enable = 1'b0;
    step();
    chk("hold_idx", idx, 0);
    chk("hold_wrap", wrap, 0);

    // program table, then wrap mode down
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_addr = 3'(i);
      wr_data = 8'(t_dat[i]);
      step();
    end
    wr_en = 1'b0;
    chk("wr_seq0", seq, 2);
    up_down = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("dn_seq%0d", i), seq, d_seq[i]);
      chk($sformatf("dn_wrap%0d", i), wrap, d_wr[i]);
    end

    // bounce mode, up_down toggling ignored
    enable  = 1'b0;
    restart = 1'b1;
    step();
    chk("rs_idx", idx, 0);
    restart  = 1'b0;
    mode     = 2'b01;
    last_idx = 3'd3;
    enable   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      up_down = ~up_down;
      step();
      chk($sformatf("bn_idx%0d", i), idx, b_idx[i]);
      chk($sformatf("bn_wrap%0d", i), wrap, b_wr[i]);
      if (i == 2)
        chk("bn_seq3", seq, 7);
    end

    // one-shot up, length 3
    enable  = 1'b0;
    restart = 1'b1;
    step();
    restart  = 1'b0;
    mode     = 2'b10;
    last_idx = 3'd2;
    up_down  = 1'b1;
    enable   = 1'b1;
    step();
    chk("os_idx1", idx, 1);
    step();
    chk("os_idx2", idx, 2);
    chk("os_done2", done, 0);
    step();
    chk("os_idx3", idx, 2);
    chk("os_done3", done, 1);
    chk("os_wrap3", wrap, 1);
    step();
    chk("os_idx4", idx, 2);
    chk("os_done4", done, 1);
    chk("os_wrap4", wrap, 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("os_rs_idx", idx, 0);
    chk("os_rs_done", done, 0);

    // one-shot down at 0, then leave mode
    up_down = 1'b0;
    step();
    chk("osd_idx", idx, 0);
    chk("osd_done", done, 1);
    chk("osd_wrap", wrap, 1);
    enable = 1'b0;
    mode   = 2'b00;
    step();
    chk("osd_clr", done, 0);

    // out-of-range recovery
    restart = 1'b1;
    step();
    restart  = 1'b0;
    last_idx = 3'd7;
    up_down  = 1'b1;
    enable   = 1'b1;
    repeat (6) step();
    chk("oor_pre", idx, 6);
    chk("oor_seq6", seq, 6);
    last_idx = 3'd3;
    step();
    chk("oor_idx", idx, 0);
    chk("oor_wrap", wrap, 0);
    chk("oor_seq", seq, 2);

    // bounce with length 1
    mode     = 2'b01;
    last_idx = 3'd0;
    step();
    chk("b1_idx", idx, 0);
    chk("b1_wrap", wrap, 1);
    step();
    chk("b1_wrap2", wrap, 1);

    // write and step on the same edge
    mode     = 2'b00;
    last_idx = 3'd7;
    wr_en    = 1'b1;
    wr_addr  = 3'd1;
    wr_data  = 8'hAA;
    step();
    chk("ws_idx", idx, 1);
    chk("ws_seq", seq, 8'hAA);
    wr_addr = 3'd5;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    repeat (3) step();
    chk("ws_idx5", idx, 5);
    chk("ws_seq5", seq, 8'h55);

    // asynchronous reset mid-sequence
    #2;
    rst = 1'b0;
    #1;
    chk("ar_idx", idx, 0);
    chk("ar_seq", seq, 0);
    chk("ar_wrap", wrap, 0);
    chk("ar_done", done, 0);
    step();
    rst = 1'b1;
    step();
    chk("ar_idx1", idx, 1);
    chk("ar_tbl1", seq, 1);
    repeat (4) step();
    chk("ar_tbl5", seq, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_table_gen.md
Name: seq_table_gen

Overview:
Parametrised table-driven sequence generator. It steps an index through a runtime-writable table of W-bit codes and presents the selected code on seq. It supports up/down stepping, three sequencing modes (wrap, bounce, one-shot) and a programmable sequence length. It is the generalised successor to the fixed 4-bit up/down code FSM and sits in the same control paths, driving pattern and code outputs from clk.

Parameters:
W, 8, width of each table entry and of seq
DEPTH, 8, number of table entries (power of 2, >=2); AW = $clog2(DEPTH) is a localparam

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
enable  in  1  advance one step on this edge
up_down  in  1  1 = increment index, 0 = decrement (wrap and one-shot modes only)
mode  in  2  00 wrap, 01 bounce, 10 one-shot, 11 treated as wrap
last_idx  in  AW  index of final table entry (sequence length = last_idx+1)
restart  in  1  synchronous return to start
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_data  in  W  table write data
seq  out  W  table[idx], combinational read of registered idx and table
idx  out  AW  current index
wrap  out  1  registered one-cycle pulse on a sequence-end transition
done  out  1  sticky, one-shot complete

Behaviour:
- Reset (rst=0, async):
  - idx=0, internal dir=up, wrap=0, done=0.
  - table[i]=i (zero-extended to W), so seq=0.
- Table writes:
  - wr_en writes table[wr_addr] at the edge. seq shows the new value from the next cycle.
  - A write is independent of stepping; a write and a step can occur on the same edge.
- Priority per edge: restart > enable.
  - restart: idx=0, dir=up, done=0, wrap=0.
- enable=0: idx, dir and done hold; wrap=0.
- Out-of-range index: if idx > last_idx when enabled (last_idx lowered mid-run), then idx=0, dir=up, no wrap. This is the recovery path, analogous to a default state.
- Wrap mode, stepping with up_down:
  - up at last_idx → 0, wrap=1.
  - down at 0 → last_idx, wrap=1.
  - otherwise idx±1.
- Bounce mode (up_down ignored; internal dir used):
  - up at last_idx → last_idx-1, dir=down, wrap=1.
  - down at 0 → 1, dir=up, wrap=1.
  - last_idx=0: idx stays 0, wrap=1 on every enabled edge.
- One-shot mode:
  - Steps like wrap mode.
  - Stepping past the end (up at last_idx, or down at 0): idx holds, done=1, wrap=1 for one cycle.
  - While done=1, enable has no effect.
  - done clears only on restart, on reset, or on the edge after mode leaves 10.
- Changing mode mid-run: no idx jump. Bounce continues from current idx using the current dir.
- Latency: idx, seq and wrap all update together one edge after the enable sample.

Optional Feature:
SEQ_TABLE_GEN_LOAD_EN
- Defined: adds ports load (in, 1) and load_idx (in, AW).
  - load=1 with restart=0 sets idx=load_idx (clamped to last_idx) and clears done. No wrap.
  - Priority: restart > load > enable.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset, then enable=1, up_down=1, mode=00, last_idx=4 → seq 0,1,2,3,4,0. wrap=1 only in the cycle seq returns to 0.
- Write table[0..4]=2,3,5,7,10, mode=00, up_down=0 from idx=0 → seq 10,7,5,3,2,10. wrap on each 2→10 step.
- mode=01, last_idx=3, enable held → idx 0,1,2,3,2,1,0,1. wrap=1 when idx=2 after 3 and when idx=1 after 0. up_down toggling has no effect.
- mode=10, last_idx=2, up → idx 0,1,2,2. done=1 from the 4th cycle. Further enables keep idx=2. restart → idx=0, done=0.
- idx=6 with last_idx=7, then set last_idx=3 and enable → idx=0, wrap=0.
- Assert rst mid-sequence at idx=5 → idx=0, done=0, wrap=0 immediately (asynchronous). Table reverts to identity.
